layers_frame_merger: RTL and testbench
======================================

// Module: layers_frame_merger
// PURPOSE
// - Frame-aware N:1 AXI-Stream merger for the per-layer MISO frame streams, feeding the readout frames FIFO.
// - Grants one layer per frame with round-robin fairness and holds the grant until tlast.
// - Enforces a maximum frame length: over-long frames are truncated and their tail is drained.
// - Tags every output beat with the source layer ID. Provides per-layer enables and frame statistics.
// PARAMETERS
// - LAYER_COUNT    5     number of slave (layer) ports, 1..16
// - DATA_WIDTH     8     tdata width per port
// - MAX_FRAME_LEN  64    max beats per output frame (incl. header), >=2
// PORTS
// - clk_core              in   1                       core clock; all logic on its rising edge
// - clk_core_rst          in   1                       synchronous reset, active-high
// - s_axis_tdata          in   LAYER_COUNT*DATA_WIDTH  layer li occupies [li*DATA_WIDTH +: DATA_WIDTH]
// - s_axis_tvalid         in   LAYER_COUNT             per-layer valid
// - s_axis_tlast          in   LAYER_COUNT             per-layer end of frame
// - s_axis_tready         out  LAYER_COUNT             per-layer ready
// - m_axis_tdata          out  DATA_WIDTH              merged data
// - m_axis_tdest          out  8                       source layer ID = index+1
// - m_axis_tlast          out  1                       end of output frame
// - m_axis_tvalid         out  1                       merged valid
// - m_axis_tready         in   1                       downstream ready
// - cfg_layers_enable     in   LAYER_COUNT             1 = layer may be granted
// - status_grant          out  LAYER_COUNT             one-hot current grant; 0 when IDLE
// - status_truncated      out  LAYER_COUNT             1-cycle pulse when a frame of that layer is cut
// - stat_frames_count     out  32                      output frames completed; wraps at 2^32
// BEHAVIOUR
// - Reset values:
//   - all outputs are 0.
//   - rr_ptr = LAYER_COUNT-1, so layer 0 has priority first.
//   - State = IDLE. Output register is empty.
// - Output register (one stage):
//   - m_axis_* is registered.
//   - Slave beat accepted when s_tvalid[g] & s_tready[g].
//   - The accepted beat appears on m_axis the next cycle.
//   - m_axis_* is held stable while m_tvalid & !m_tready.
//   - load_ok = !m_tvalid | m_tready.
// - FSM:
//   - IDLE:
//     - candidates = s_tvalid & cfg_layers_enable.
//     - Grant the first candidate scanning rr_ptr+1 .. rr_ptr+LAYER_COUNT, modulo LAYER_COUNT.
//     - Register g and set rr_ptr <= g; go to HEADER (macro on) or STREAM.
//     - No candidates: stay in IDLE.
//     - Exactly one idle cycle between frames (arbitration bubble).
//   - HEADER:
//     - When load_ok, load header beat: tdata = g+1 (zero-extended), tlast = 0.
//     - Set beat_cnt = 1 and go to STREAM.
//     - No slave beat is consumed in this state.
//   - STREAM:
//     - s_tready[g] = load_ok; every other s_tready = 0.
//     - Each accepted beat is forwarded and beat_cnt increments.
//     - Accepted beat with s_tlast: forward it with m_tlast = 1, then go to IDLE.
//     - Accepted beat without s_tlast that makes beat_cnt == MAX_FRAME_LEN:
//       - forward it with m_tlast = 1;
//       - pulse status_truncated[g];
//       - go to DRAIN.
//   - DRAIN:
//     - s_tready[g] = 1; accepted beats are discarded (not forwarded).
//     - Go to IDLE on the accepted s_tlast beat.
// - Grant is sampled only in IDLE.
//   - Clearing cfg_layers_enable[g] mid-frame does not abort the frame.
//   - A disabled layer is never granted and its s_tready stays 0.
// - beat_cnt is $clog2(MAX_FRAME_LEN+1) bits wide, cleared in IDLE, never wraps.
// - stat_frames_count increments on each m_tvalid & m_tready & m_tlast.
// - A frame whose tlast lands exactly on beat MAX_FRAME_LEN is a normal end: no truncation pulse, no DRAIN.
// - A single-beat frame (tvalid & tlast on the first beat) is legal.
// - m_axis_tdest = g+1 on every beat of the frame, header included.
// - Reset mid-frame:
//   - state returns to IDLE and the output register is cleared;
//   - rr_ptr returns to LAYER_COUNT-1; counters are cleared;
//   - a partial frame is lost.
// CONFIGURATION
// - LAYERS_FRAME_MERGER_HEADER_EN defined:
//   - HEADER state is present; each frame starts with a layer-ID beat;
//   - the header counts toward MAX_FRAME_LEN.
// - Macro not defined:
//   - HEADER state is removed; IDLE goes to STREAM;
//   - beat_cnt starts at 0; the layer ID is carried only on tdest.
// TESTING
// - T1 fairness: layers 0,1,2 hold 3-beat frames, m_tready=1.
//   -> output order 0,1,2,0,1,2; each frame is 3 beats (4 with header); stat_frames_count=6 after 6 frames.
// - T2 backpressure: m_tready toggles 1010...
//   -> no beat lost or duplicated; m_axis_tdata is stable while stalled; s_tready[g]=0 whenever load_ok=0.
// - T3 truncation: MAX_FRAME_LEN=8, macro off, layer 3 sends a 12-beat frame.
//   -> 8 beats out with tlast on beat 8; status_truncated[3] pulses once; beats 9..12 consumed silently;
//   -> the next frame is intact.
// - T4 boundary: 8-beat frame with tlast on beat 8.
//   -> no truncation pulse; next grant follows one IDLE cycle later.
// - T5 enable: cfg_layers_enable=5'b11110 with layer 0 valid.
//   -> layer 0 is never granted and s_tready[0]=0.
//   Clear enable[1] mid-frame -> the frame completes.
// - T6 reset: assert clk_core_rst for one cycle on beat 2 of a frame.
//   -> next cycle all outputs are 0 and status_grant=0; layer 0 wins the next arbitration.

Source files
------------

// File: rtl/layers_frame_merger.sv
// layers_frame_merger
// Frame-aware N:1 AXI-Stream merger. One layer is granted per frame
// (round-robin) and keeps the grant until its tlast. Frames longer than
// MAX_FRAME_LEN beats are cut: the last forwarded beat carries tlast and
// the remainder of the source frame is drained silently. Every output beat
// carries the source layer ID (index+1) on tdest.
//
// Optional feature: define LAYERS_FRAME_MERGER_HEADER_EN to prefix every
// frame with a header beat holding the layer ID. The header counts toward
// MAX_FRAME_LEN. Without the macro the layer ID travels only on tdest.
//
// Handshake: a beat moves across an interface on a rising edge where both
// tvalid and tready are high. The master side never retracts or alters a
// beat while tvalid is high and tready is low, and slave tready never
// depends on the same slave's tvalid.

module layers_frame_merger #(
  parameter int LAYER_COUNT   = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 64
) (
  input  logic                              clk_core,
  input  logic                              clk_core_rst,
  input  logic [LAYER_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT-1:0]            s_axis_tvalid,
  input  logic [LAYER_COUNT-1:0]            s_axis_tlast,
  output logic [LAYER_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [7:0]                        m_axis_tdest,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic [LAYER_COUNT-1:0]            cfg_layers_enable,
  output logic [LAYER_COUNT-1:0]            status_grant,
  output logic [LAYER_COUNT-1:0]            status_truncated,
  output logic [31:0]                       stat_frames_count
);

  localparam int IW = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
  localparam int CW = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME_LEN);

  localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef LAYERS_FRAME_MERGER_HEADER_EN
  localparam logic [1:0] ST_HEADER = 2'd1;
`endif
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Control state
  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         g_q, g_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Output register
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [7:0]            m_dest_q, m_dest_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;

  // Status
  logic [LAYER_COUNT-1:0] trunc_q, trunc_d;
  logic [31:0]            frames_q, frames_d;

  // Arbitration and datapath helpers
  logic [LAYER_COUNT-1:0] cand;
  logic [IW-1:0]          arb_scan;
  logic [IW-1:0]          arb_idx;
  logic                   arb_found;
  logic [LAYER_COUNT-1:0] ready;
  logic                   load_ok;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [CW-1:0]          cnt_inc;

  // The output register can take a new beat when it is empty or being emptied.
  assign load_ok   = !m_valid_q || m_axis_tready;
  assign sel_valid = s_axis_tvalid[g_q];
  assign sel_last  = s_axis_tlast[g_q];
  assign sel_data  = s_axis_tdata[g_q*DATA_WIDTH +: DATA_WIDTH];
  assign cnt_inc   = cnt_q + 1'b1;

  // Round-robin pick: first enabled, valid layer after rr_q (wrapping).
  // The scan runs from the farthest offset down so the nearest hit wins.
  always_comb begin
    cand      = s_axis_tvalid & cfg_layers_enable;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_scan  = '0;
    for (int i = LAYER_COUNT; i >= 1; i--) begin
      arb_scan = IW'((int'(rr_q) + i) % LAYER_COUNT);
      if (cand[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = arb_scan;
      end
    end
  end

  // Next-state logic for the frame FSM, output register and statistics.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_dest_d  = m_dest_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q && !m_axis_tready;
    trunc_d   = '0;
    ready     = '0;
    frames_d  = frames_q;

    if (m_valid_q && m_axis_tready && m_last_q) begin
      frames_d = frames_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_found) begin
          g_d  = arb_idx;
          rr_d = arb_idx;
`ifdef LAYERS_FRAME_MERGER_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_STREAM;
`endif
        end
      end

`ifdef LAYERS_FRAME_MERGER_HEADER_EN
      ST_HEADER: begin
        if (load_ok) begin
          m_data_d  = DATA_WIDTH'(int'(g_q) + 1);
          m_dest_d  = 8'(int'(g_q) + 1);
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          cnt_d     = CW'(1);
          state_d   = ST_STREAM;
        end
      end
`endif

      ST_STREAM: begin
        ready[g_q] = load_ok;
        if (sel_valid && load_ok) begin
          cnt_d     = cnt_inc;
          m_data_d  = sel_data;
          m_dest_d  = 8'(int'(g_q) + 1);
          m_valid_d = 1'b1;
          if (sel_last) begin
            // Natural end, including a tlast that lands exactly on the limit.
            m_last_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (cnt_inc == MAX_CNT) begin
            // Limit reached mid-frame: close the output frame, drop the rest.
            m_last_d   = 1'b1;
            trunc_d[g_q] = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            m_last_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        ready[g_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      state_q   <= ST_IDLE;
      g_q       <= '0;
      rr_q      <= IW'(LAYER_COUNT - 1);
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_dest_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      trunc_q   <= '0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_dest_q  <= m_dest_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      trunc_q   <= trunc_d;
      frames_q  <= frames_d;
    end
  end

  // One-hot grant, visible only while a frame is owned.
  always_comb begin
    status_grant = '0;
    if (state_q != ST_IDLE) begin
      status_grant[g_q] = 1'b1;
    end
  end

  assign s_axis_tready     = ready;
  assign m_axis_tdata      = m_data_q;
  assign m_axis_tdest      = m_dest_q;
  assign m_axis_tlast      = m_last_q;
  assign m_axis_tvalid     = m_valid_q;
  assign status_truncated  = trunc_q;
  assign stat_frames_count = frames_q;

endmodule

// File: tb/tb_layers_frame_merger.sv
// Bench for layers_frame_merger (default build, header beat disabled),
// five layers, 8-bit data, MAX_FRAME_LEN = 8.
`timescale 1ns/1ps

module tb_layers_frame_merger;

  localparam int LC  = 5;
  localparam int DW  = 8;
  localparam int MFL = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [LC*DW-1:0] s_tdata;
  logic [LC-1:0]    s_tvalid;
  logic [LC-1:0]    s_tlast;
  logic [LC-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [7:0]       m_tdest;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [LC-1:0]    cfg_en;
  logic [LC-1:0]    st_grant;
  logic [LC-1:0]    st_trunc;
  logic [31:0]      frames_cnt;

  layers_frame_merger #(
    .LAYER_COUNT  (LC),
    .DATA_WIDTH   (DW),
    .MAX_FRAME_LEN(MFL)
  ) dut (
    .clk_core         (clk),
    .clk_core_rst     (rst),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tdest     (m_tdest),
    .m_axis_tlast     (m_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .cfg_layers_enable(cfg_en),
    .status_grant     (st_grant),
    .status_truncated (st_trunc),
    .stat_frames_count(frames_cnt)
  );

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;

  // Expected output beats: {tdest, tlast, tdata}
  logic [16:0] exp_q[$];

  // Per-layer source buffers: {tlast, tdata}
  logic [8:0] src_mem [LC][32];
  int         src_head [LC];
  int         src_tail [LC];

  logic        sb_on;
  logic        bp_chk;
  logic        en_chk;
  logic        prev_stall;
  logic [16:0] prev_out;
  int          trunc_cnt [LC];
  int          exp_frames;

  typedef struct {
    int layer;
    int len;
    int nout;
    int ntrunc;
  } vec_t;

  vec_t tbl [8];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic present();
    for (int li = 0; li < LC; li++) begin
      if (src_head[li] < src_tail[li]) begin
        s_tvalid[li]          = 1'b1;
        s_tlast[li]           = src_mem[li][src_head[li]][8];
        s_tdata[li*DW +: DW]  = src_mem[li][src_head[li]][7:0];
      end else begin
        s_tvalid[li]          = 1'b0;
        s_tlast[li]           = 1'b0;
        s_tdata[li*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic push_frame(input int layer, input int len, input int base);
    if (src_head[layer] == src_tail[layer]) begin
      src_head[layer] = 0;
      src_tail[layer] = 0;
    end
    for (int b = 0; b < len; b++) begin
      src_mem[layer][src_tail[layer]] = {(b == len - 1), 8'(base + b)};
      src_tail[layer]++;
    end
  endtask

  task automatic exp_frame(input int layer, input int nout, input int base);
    for (int b = 0; b < nout; b++) begin
      exp_q.push_back({8'(layer + 1), (b == nout - 1), 8'(base + b)});
    end
  endtask

  // One clock: observe at the falling edge, then update sources after the rising edge.
  task automatic step();
    logic [LC-1:0] s_fire;
    logic [16:0]   e;
    @(negedge clk);
    s_fire = s_tvalid & s_tready;
    if (prev_stall) begin
      check("stall_hold", {13'd0, m_tvalid, m_tdest, m_tlast, m_tdata}, {13'd0, 1'b1, prev_out});
    end
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_out   = {m_tdest, m_tlast, m_tdata};
    if (bp_chk && m_tvalid && !m_tready) begin
      check("tready_while_stalled", 32'(s_tready), 32'd0);
    end
    if (en_chk) begin
      check("disabled_l0_ready", 32'(s_tready[0]), 32'd0);
      check("disabled_l0_grant", 32'(st_grant[0]), 32'd0);
    end
    if (sb_on && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got 0x%0h required none at %0t",
                 {m_tdest, m_tlast, m_tdata}, $time);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({m_tdest, m_tlast, m_tdata}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int li = 0; li < LC; li++) begin
      if (s_fire[li]) src_head[li]++;
      trunc_cnt[li] += int'(st_trunc[li]);
    end
    present();
  endtask

  task automatic wait_done(input logic [LC-1:0] mask, input string name);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      step();
      n++;
      done = (exp_q.size() == 0) && !m_tvalid;
      for (int li = 0; li < LC; li++) begin
        if (mask[li] && (src_head[li] < src_tail[li])) done = 1'b0;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic clear_trunc();
    for (int li = 0; li < LC; li++) trunc_cnt[li] = 0;
  endtask

  // Hard stop in case a task loop misbehaves.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int   n;
    int   idle;
    int   seed;
    logic done;

    tbl[0] = '{0, 1,  1, 0};  // single-beat frame
    tbl[1] = '{2, 3,  3, 0};
    tbl[2] = '{1, 8,  8, 0};  // tlast exactly on the limit
    tbl[3] = '{3, 12, 8, 1};  // over-long: cut to 8, 4 beats drained
    tbl[4] = '{3, 5,  5, 0};  // next frame from same layer intact
    tbl[5] = '{4, 9,  8, 1};  // one beat over
    tbl[6] = '{2, 7,  7, 0};
    tbl[7] = '{0, 2,  2, 0};

    rst        = 1'b1;
    s_tdata    = '0;
    s_tvalid   = '0;
    s_tlast    = '0;
    m_tready   = 1'b0;
    cfg_en     = 5'b11111;
    sb_on      = 1'b1;
    bp_chk     = 1'b0;
    en_chk     = 1'b0;
    prev_stall = 1'b0;
    prev_out   = '0;
    exp_frames = 0;
    seed       = 16;
    for (int li = 0; li < LC; li++) begin
      src_head[li]  = 0;
      src_tail[li]  = 0;
      trunc_cnt[li] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_m_tdata",  32'(m_tdata),  32'd0);
    check("rst_m_tdest",  32'(m_tdest),  32'd0);
    check("rst_m_tlast",  32'(m_tlast),  32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_grant",    32'(st_grant), 32'd0);
    check("rst_trunc",    32'(st_trunc), 32'd0);
    check("rst_frames",   frames_cnt,    32'd0);

    m_tready = 1'b1;

    // T1 fairness: two 3-beat frames on layers 0,1,2 -> order 0,1,2,0,1,2
    for (int r = 0; r < 2; r++) begin
      for (int li = 0; li < 3; li++) begin
        push_frame(li, 3, seed);
        exp_frame(li, 3, seed);
        seed += 3;
      end
    end
    present();
    wait_done(5'b11111, "t1_done");
    exp_frames += 6;
    check("t1_frames", frames_cnt, 32'(exp_frames));

    // T2 backpressure: m_tready 1010...; rr is at layer 2, so layer 3 then 1
    bp_chk = 1'b1;
    push_frame(3, 5, seed);
    exp_frame(3, 5, seed);
    seed += 5;
    push_frame(1, 5, seed);
    exp_frame(1, 5, seed);
    seed += 5;
    present();
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      m_tready = (n % 2 == 0);
      step();
      n++;
      done = (exp_q.size() == 0) && !m_tvalid &&
             (src_head[1] == src_tail[1]) && (src_head[3] == src_tail[3]);
    end
    check("t2_done", 32'(done), 32'd1);
    m_tready = 1'b1;
    bp_chk   = 1'b0;
    exp_frames += 2;
    check("t2_frames", frames_cnt, 32'(exp_frames));

    // Table: single-frame vectors including truncation and the exact-limit case
    for (int i = 0; i < 8; i++) begin
      clear_trunc();
      push_frame(tbl[i].layer, tbl[i].len, seed);
      exp_frame(tbl[i].layer, tbl[i].nout, seed);
      seed += tbl[i].len;
      present();
      wait_done(5'b11111, "tbl_done");
      exp_frames++;
      check("tbl_frames", frames_cnt, 32'(exp_frames));
      check("tbl_trunc", 32'(trunc_cnt[tbl[i].layer]), 32'(tbl[i].ntrunc));
    end

    // T4 boundary: 8-beat frame ends on the limit, next grant after one idle cycle.
    // rr is at layer 0, so layer 1 is granted before layer 2.
    clear_trunc();
    push_frame(1, 8, seed);
    exp_frame(1, 8, seed);
    seed += 8;
    push_frame(2, 1, seed);
    exp_frame(2, 1, seed);
    seed += 1;
    present();
    n = 0;
    while (st_grant != 5'b00010 && n < 50) begin
      step();
      n++;
    end
    check("t4_grant1", 32'(st_grant), 32'h2);
    idle = 0;
    n    = 0;
    while (st_grant != 5'b00100 && n < 50) begin
      step();
      n++;
      if (st_grant == '0) idle++;
    end
    check("t4_grant2", 32'(st_grant), 32'h4);
    check("t4_idle_gap", 32'(idle), 32'd1);
    wait_done(5'b11111, "t4_done");
    check("t4_no_trunc", 32'(trunc_cnt[1]), 32'd0);
    exp_frames += 2;
    check("t4_frames", frames_cnt, 32'(exp_frames));

    // T5 enables: layer 0 disabled but valid; layer 1 disabled mid-frame still completes
    cfg_en = 5'b11110;
    en_chk = 1'b1;
    push_frame(0, 2, seed);
    seed += 2;
    push_frame(1, 4, seed);
    exp_frame(1, 4, seed);
    seed += 4;
    present();
    n = 0;
    while (st_grant != 5'b00010 && n < 50) begin
      step();
      n++;
    end
    check("t5_grant1", 32'(st_grant), 32'h2);
    step();
    step();
    cfg_en = 5'b11100;
    wait_done(5'b00010, "t5_l1_done");
    exp_frames++;
    check("t5_frames", frames_cnt, 32'(exp_frames));
    repeat (10) step();
    check("t5_l0_pending", 32'(src_tail[0] - src_head[0]), 32'd2);
    en_chk = 1'b0;
    cfg_en = 5'b11111;
    exp_frame(0, 2, seed - 6);
    wait_done(5'b11111, "t5_l0_done");
    exp_frames++;
    check("t5_frames_after", frames_cnt, 32'(exp_frames));

    // T6 reset on beat 2 of a layer-0 frame; layer 0 must win afterwards over layer 1
    sb_on = 1'b0;
    push_frame(0, 5, seed);
    seed += 5;
    present();
    n = 0;
    while (st_grant != 5'b00001 && n < 50) begin
      step();
      n++;
    end
    check("t6_grant0", 32'(st_grant), 32'h1);
    push_frame(1, 3, seed);
    present();
    n = 0;
    while ((src_tail[0] - src_head[0]) > 3 && n < 50) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_m_tvalid", 32'(m_tvalid), 32'd0);
    check("t6_m_tdata",  32'(m_tdata),  32'd0);
    check("t6_m_tdest",  32'(m_tdest),  32'd0);
    check("t6_m_tlast",  32'(m_tlast),  32'd0);
    check("t6_grant",    32'(st_grant), 32'd0);
    check("t6_s_tready", 32'(s_tready), 32'd0);
    check("t6_frames",   frames_cnt,    32'd0);
    exp_frames = 0;
    prev_stall = 1'b0;
    sb_on      = 1'b1;
    // What is still buffered for layer 0 is re-sent as a fresh frame.
    for (int j = src_head[0]; j < src_tail[0]; j++) begin
      exp_q.push_back({8'd1, src_mem[0][j][8], src_mem[0][j][7:0]});
    end
    exp_frame(1, 3, seed);
    seed += 3;
    n = 0;
    while (st_grant == '0 && n < 50) begin
      step();
      n++;
    end
    check("t6_first_grant", 32'(st_grant), 32'h1);
    wait_done(5'b11111, "t6_done");
    exp_frames += 2;
    check("t6_frames_after", frames_cnt, 32'(exp_frames));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
